pipe_cla_addsub: RTL and testbench

//   Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshake.

---
 rtl/pipe_cla_addsub.sv | 140 ++++++++++++++
 tb/tb_pipe_cla_addsub.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: STAGES slices of WIDTH/STAGES bits, one slice per stage.
// Define SATURATE_EN to clamp signed overflow in the final stage; otherwise the sum wraps.
module pipe_cla_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = WIDTH / STAGES;

  // Returns {carry out, carry into MSB, sum} of one slice; each carry is a flat sum of products.
  // NOTE: blocking assignments here build combinational values; only clocked state uses <=.
  function automatic logic [SW+1:0] cla_slice(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                               input logic ci);
    logic [SW-1:0] g, p;
    logic [SW:0]   c;
    logic          acc, pp;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    for (int i = 0; i < SW; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & ci);
    end
    return {c[SW], c[SW-1], p ^ c[SW-1:0]};
  endfunction

  logic [STAGES-1:0] r_vld;
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [WIDTH-1:0]  r_res [STAGES];
  logic              r_c   [STAGES];
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout, r_ovf, r_zero;

  logic [WIDTH-1:0]  w_a    [STAGES];
  logic [WIDTH-1:0]  w_b    [STAGES];
  logic [WIDTH-1:0]  w_rin  [STAGES];
  logic [WIDTH-1:0]  w_rout [STAGES];
  logic              w_cin  [STAGES];
  logic [SW+1:0]     w_sl   [STAGES];
  logic [STAGES-1:0] w_vin;
  logic              w_adv;

  assign out_valid = r_vld[STAGES-1];
  assign w_adv     = ~(out_valid & ~out_ready);
  assign in_ready  = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [WIDTH-1:0] MASK = WIDTH'({SW{1'b1}}) << (k * SW);
    if (k == 0) begin : g_first
      assign w_a[k]   = a;
      assign w_b[k]   = sub ? ~b : b;
      assign w_cin[k] = sub | cin;
      assign w_rin[k] = '0;
      assign w_vin[k] = in_valid;
    end else begin : g_next
      assign w_a[k]   = r_a[k-1];
      assign w_b[k]   = r_b[k-1];
      assign w_cin[k] = r_c[k-1];
      assign w_rin[k] = r_res[k-1];
      assign w_vin[k] = r_vld[k-1];
    end
    assign w_sl[k]   = cla_slice(w_a[k][k*SW +: SW], w_b[k][k*SW +: SW], w_cin[k]);
    assign w_rout[k] = (w_rin[k] & ~MASK) | (WIDTH'(w_sl[k][SW-1:0]) << (k * SW));
  end

  logic             w_fcout, w_fovf, w_fzero;
  logic [WIDTH-1:0] w_fsum;

  assign w_fcout = w_sl[STAGES-1][SW+1];
  assign w_fovf  = w_sl[STAGES-1][SW+1] ^ w_sl[STAGES-1][SW];
`ifdef SATURATE_EN
  // Carry out distinguishes the direction: set means two negatives overflowed.
  always_comb begin
    w_fsum = w_rout[STAGES-1];
    if (w_fovf) w_fsum = {w_fcout, {(WIDTH-1){~w_fcout}}};
  end
`else
  assign w_fsum = w_rout[STAGES-1];
`endif
  assign w_fzero = (w_fsum == '0);

  always_ff @(posedge clk) begin
    if (rst) r_vld <= '0;
    else if (w_adv) r_vld <= w_vin;
  end

  // NOTE: intermediate datapath registers carry no reset; their valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= w_a[k];
        r_b[k]   <= w_b[k];
        r_res[k] <= w_rout[k];
        r_c[k]   <= w_sl[k][SW+1];
      end
    end
  end

  // Result and flags load only with a valid op, so they hold across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_adv && w_vin[STAGES-1]) begin
      r_sum  <= w_fsum;
      r_cout <= w_fcout;
      r_ovf  <= w_fovf;
      r_zero <= w_fzero;
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = r_zero;

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Scoreboard bench for pipe_cla_addsub: directed corner cases, stall, mid-flight reset and random traffic.
// Honours SATURATE_EN in its reference model.
module tb_pipe_cla_addsub;

  parameter int WIDTH  = 16;
  parameter int STAGES = 4;
  localparam int N_RANDOM = 10000;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    int               acc_cyc;
    bit               chk_lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin, sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout, ovf, zero;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   stall_cycles = 0;

  localparam logic [WIDTH-1:0] ALL1 = '1;
  localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINN = {1'b1, {(WIDTH-1){1'b0}}};

  pipe_cla_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands, no carry chains.
  function automatic exp_t model(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                 input logic icin, input logic isub);
    exp_t        e;
    longint      sa, sbv, r, maxs, mins;
    logic [WIDTH:0] u;
    maxs = (longint'(1) <<< (WIDTH - 1)) - 1;
    mins = -(longint'(1) <<< (WIDTH - 1));
    sa   = longint'($signed(ia));
    sbv  = longint'($signed(ib));
    if (isub) begin
      e.sum  = ia - ib;
      e.cout = (ia >= ib);
      r      = sa - sbv;
    end else begin
      u      = {1'b0, ia} + {1'b0, ib} + {{WIDTH{1'b0}}, icin};
      e.sum  = u[WIDTH-1:0];
      e.cout = u[WIDTH];
      r      = sa + sbv + longint'(icin);
    end
    e.ovf = (r > maxs) || (r < mins);
`ifdef SATURATE_EN
    if (r > maxs) e.sum = MAXP;
    else if (r < mins) e.sum = MINN;
`endif
    e.zero    = (e.sum == '0);
    e.acc_cyc = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  function automatic logic [WIDTH-1:0] rnd_op();
    logic [WIDTH-1:0] v;
    v = WIDTH'({$urandom, $urandom});
    case ($urandom_range(0, 9))
      0: v = '0;
      1: v = ALL1;
      2: v = MAXP;
      3: v = MINN;
      4: v = WIDTH'(1);
      default: ;
    endcase
    return v;
  endfunction

  task automatic push_expected(input bit lat);
    exp_t e;
    e = model(a, b, cin, sub);
    e.acc_cyc = cyc + 1;
    e.chk_lat = lat;
    sb.push_back(e);
  endtask

  // Called at a falling edge; returns at a falling edge after the op is accepted.
  task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       input logic icin, input logic isub, input bit lat);
    bit accepted = 1'b0;
    a = ia; b = ib; cin = icin; sub = isub;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      #1;
      accepted = in_ready;
      if (accepted) push_expected(lat);
      @(negedge clk);
      if (accepted) break;
    end
    in_valid = 1'b0;
    if (!accepted) check("issue_timeout", 64'(in_ready), 64'(1));
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  // Monitor: pops one expectation per output transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (out_valid && !out_ready) begin
          stall_cycles++;
          check("in_ready_while_stalled", 64'(in_ready), 64'(0));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_output", 64'(out_valid), 64'(0));
          end else begin
            e = sb.pop_front();
            check("sum",  64'(sum),  64'(e.sum));
            check("cout", 64'(cout), 64'(e.cout));
            check("ovf",  64'(ovf),  64'(e.ovf));
            check("zero", 64'(zero), 64'(e.zero));
            if (e.chk_lat) check("latency", 64'(cyc - e.acc_cyc + 1), 64'(STAGES));
          end
        end
      end
    end
  end

  initial begin
    int n_acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum",       64'(sum),       64'(0));
    check("rst_cout",      64'(cout),      64'(0));
    check("rst_ovf",       64'(ovf),       64'(0));
    check("rst_zero",      64'(zero),      64'(0));
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 64'(in_ready), 64'(1));
    @(negedge clk);

    // Directed corner cases
    issue(WIDTH'(16'h1234), WIDTH'(16'h4321), 1'b0, 1'b0, 1'b1);
    drain();
    issue(ALL1, WIDTH'(1), 1'b0, 1'b0, 1'b0);
    issue(MAXP, WIDTH'(1), 1'b0, 1'b0, 1'b0);
    issue(WIDTH'(5), WIDTH'(7), 1'b0, 1'b1, 1'b0);
    issue(WIDTH'(7), WIDTH'(5), 1'b0, 1'b1, 1'b0);
    issue(MINN, WIDTH'(1), 1'b0, 1'b1, 1'b0);
    issue(WIDTH'(7), WIDTH'(5), 1'b1, 1'b1, 1'b0);
    issue(MINN, MINN, 1'b0, 1'b0, 1'b0);
    issue(ALL1, ALL1, 1'b1, 1'b0, 1'b0);
    drain();

    // Back-to-back stream with the consumer stalling mid-stream
    stall_cycles = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) issue(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), 1'b0);
      end
      begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          out_ready = !(c >= 4 && c < 8);
        end
      end
    join
    drain();
    check("stall_observed", 64'(stall_cycles > 0), 64'(1));

    // Reset with ops in flight, then a fresh op
    for (int i = 0; i < 3; i++) issue(rnd_op(), rnd_op(), 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("rst_flush_out_valid", 64'(out_valid), 64'(0));
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue(WIDTH'(16'h0F0F), WIDTH'(16'h0101), 1'b1, 1'b0, 1'b1);
    drain();

    // Random traffic with random bubbles and back-pressure
    n_acc = 0;
    for (int c = 0; c < 60000 && n_acc < N_RANDOM; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a   = rnd_op();
      b   = rnd_op();
      cin = 1'($urandom);
      sub = 1'($urandom);
      #1;
      if (in_valid && in_ready) begin
        push_expected(1'b0);
        n_acc++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("random_ops_accepted", 64'(n_acc), 64'(N_RANDOM));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
